// File: rtl/instr_fetch.sv
// instr_fetch: 6502 fetch stage, sizes each instruction from its opcode (reset-vector fetch under INSTR_FETCH_VECTOR_EN).
// Latency: OPC entry to instr_valid is len+1 cycles; one instruction per len+2 cycles with instr_ready high.
// Backpressure: bundle held stable in OUT with no memory reads until instr_ready; pc_load redirects from OPC..OUT.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    input  logic        pc_load,
    input  logic [15:0] pc_new,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_opcode,
    output logic [7:0]  instr_op1,
    output logic [7:0]  instr_op2,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc
);

`ifdef INSTR_FETCH_VECTOR_EN
    typedef enum logic [2:0] {VEC0, VEC1, VEC2, OPC, DEC, OP1, OP2, OUT} state_t;
    localparam state_t RST_STATE = VEC0;
`else
    typedef enum logic [2:0] {OPC, DEC, OP1, OP2, OUT} state_t;
    localparam state_t RST_STATE = OPC;
`endif

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  op1;
        logic [7:0]  op2;
        logic [1:0]  len;
        logic [15:0] pc;
    } bundle_t;

    state_t      state, state_nx;
    logic [15:0] pc, pc_nx;
    bundle_t     bnd, bnd_nx;
    logic        rd;
    logic [15:0] addr;
    logic        redir_ok;
    logic [1:0]  len_dec;
    logic [15:0] pc_p1, pc_p2;

    function automatic logic [1:0] op_len(input logic [7:0] o);
        logic [3:0] n;
        logic [3:0] h;
        n = o[3:0];
        h = o[7:4];
        if (n == 4'h8 || n == 4'hA || o == 8'h00 || o == 8'h40 || o == 8'h60)
            op_len = 2'd1;
        else if (n >= 4'hC || (n == 4'h9 && h[0]) || o == 8'h20)
            op_len = 2'd3;
        else
            op_len = 2'd2;
    endfunction

    assign len_dec = op_len(mem_rdata);
    assign pc_p1   = pc + 16'd1;
    assign pc_p2   = pc + 16'd2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            pc    <= RESET_PC;
            bnd   <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            bnd   <= bnd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        bnd_nx   = bnd;
        rd       = 1'b0;
        addr     = 16'h0000;
        redir_ok = 1'b1;
        case (state)
`ifdef INSTR_FETCH_VECTOR_EN
            VEC0: begin
                rd       = 1'b1;
                addr     = 16'hFFFC;
                redir_ok = 1'b0;
                state_nx = VEC1;
            end
            VEC1: begin
                rd       = 1'b1;
                addr     = 16'hFFFD;
                redir_ok = 1'b0;
                pc_nx    = {pc[15:8], mem_rdata};
                state_nx = VEC2;
            end
            VEC2: begin
                redir_ok = 1'b0;
                pc_nx    = {mem_rdata, pc[7:0]};
                state_nx = OPC;
            end
`endif
            OPC: begin
                rd       = 1'b1;
                addr     = pc;
                state_nx = DEC;
            end
            DEC: begin
                bnd_nx.opcode = mem_rdata;
                bnd_nx.op1    = 8'h00;
                bnd_nx.op2    = 8'h00;
                bnd_nx.len    = len_dec;
                bnd_nx.pc     = pc;
                if (len_dec == 2'd1) begin
                    state_nx = OUT;
                end else begin
                    rd       = 1'b1;
                    addr     = pc_p1;
                    state_nx = OP1;
                end
            end
            OP1: begin
                bnd_nx.op1 = mem_rdata;
                if (bnd.len == 2'd3) begin
                    rd       = 1'b1;
                    addr     = pc_p2;
                    state_nx = OP2;
                end else begin
                    state_nx = OUT;
                end
            end
            OP2: begin
                bnd_nx.op2 = mem_rdata;
                state_nx   = OUT;
            end
            OUT: begin
                if (instr_ready) begin
                    pc_nx    = pc + {14'd0, bnd.len};
                    state_nx = OPC;
                end
            end
            default: state_nx = OPC;
        endcase
        // A redirect overrides both the in-flight fetch and a same-cycle transfer's PC+len.
        if (pc_load && redir_ok) begin
            pc_nx    = pc_new;
            state_nx = OPC;
        end
    end

    // Memory strobe is forced low while reset is held so the port is quiet from the moment rst_n falls.
    assign mem_rd       = rst_n & rd;
    assign mem_addr     = rst_n ? addr : 16'h0000;
    assign instr_valid  = (state == OUT);
    assign instr_opcode = bnd.opcode;
    assign instr_op1    = bnd.op1;
    assign instr_op2    = bnd.op2;
    assign instr_len    = bnd.len;
    assign instr_pc     = bnd.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory model feeds the fetch port, queued expectations are
// checked by a negedge monitor for every memory read and every accepted bundle.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        pc_load;
    logic [15:0] pc_new;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_op1;
    logic [7:0]  instr_op2;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;

`ifdef INSTR_FETCH_VECTOR_EN
    localparam logic [15:0] FIRST_RD = 16'hFFFC;
    localparam logic [41:0] PARKED   = {8'hEA, 8'h00, 8'h00, 2'd1, 16'hC000};
`else
    localparam logic [15:0] FIRST_RD = 16'h0200;
    localparam logic [41:0] PARKED   = {8'hA9, 8'h10, 8'h00, 2'd2, 16'h0200};
`endif

    logic [7:0]  mem [0:65535];
    logic [15:0] rd_q [$];
    logic [41:0] bq [$];
    logic [15:0] exp_addr;
    logic [41:0] exp_bnd;
    int n_chk = 0;
    int n_pass = 0;
    int xfer_cnt = 0;
    int cyc = 0;
    int xfer_t [0:63];
    int sl [0:6] = '{2, 3, 3, 3, 3, 1, 1};

    instr_fetch #(.RESET_PC(16'h0200)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .pc_load      (pc_load),
        .pc_new       (pc_new),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_op1    (instr_op1),
        .instr_op2    (instr_op2),
        .instr_len    (instr_len),
        .instr_pc     (instr_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input string got, input string exp);
        n_chk++;
        $display("FAIL %s: got %s, expected %s", name, got, exp);
    endtask

    // Writes an instruction into memory and queues the reads (and optionally the bundle) it should produce.
    task automatic place(input logic [15:0] a, input logic [7:0] o, input logic [7:0] b1,
                         input logic [7:0] b2, input int len, input bit xfer);
        logic [15:0] a1, a2;
        logic [1:0]  l2;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        l2 = len[1:0];
        mem[a] = o;
        rd_q.push_back(a);
        if (len > 1) begin mem[a1] = b1; rd_q.push_back(a1); end
        if (len > 2) begin mem[a2] = b2; rd_q.push_back(a2); end
        if (xfer) bq.push_back({o, (len > 1) ? b1 : 8'h00, (len > 2) ? b2 : 8'h00, l2, a});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic take(input int n, input int budget);
        int target;
        int k;
        target = xfer_cnt + n;
        k = 0;
        instr_ready = 1'b1;
        while (xfer_cnt < target && k < budget) begin step(); k++; end
        instr_ready = 1'b0;
        if (xfer_cnt < target) fail("take_timeout", "too few transfers", "all transfers in budget");
    endtask

    task automatic wait_valid(input int budget);
        int k;
        k = 0;
        while (!instr_valid && k < budget) begin step(); k++; end
        if (!instr_valid) fail("valid_timeout", "instr_valid low", "instr_valid high");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_opcode"}, instr_opcode, 0);
        chk({tag, "_op1"}, instr_op1, 0);
        chk({tag, "_op2"}, instr_op2, 0);
        chk({tag, "_len"}, instr_len, 0);
        chk({tag, "_pc"}, instr_pc, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                if (rd_q.size() == 0) begin
                    fail("rd_unexpected", $sformatf("read %h", mem_addr), "no read");
                end else begin
                    exp_addr = rd_q.pop_front();
                    chk("rd_addr", mem_addr, exp_addr);
                end
            end
            if (instr_valid && instr_ready) begin
                if (bq.size() == 0) begin
                    fail("bundle_unexpected", $sformatf("pc %h", instr_pc), "no transfer");
                end else begin
                    exp_bnd = bq.pop_front();
                    chk("bundle", {instr_opcode, instr_op1, instr_op2, instr_len, instr_pc}, exp_bnd);
                end
                if (xfer_cnt < 64) xfer_t[xfer_cnt] = cyc;
                xfer_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        int nb;
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        pc_load     = 1'b0;
        pc_new      = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
`ifdef INSTR_FETCH_VECTOR_EN
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'hC0;
        rd_q.push_back(16'hFFFC);
        rd_q.push_back(16'hFFFD);
        place(16'hC000, 8'hEA, 8'h00, 8'h00, 1, 1);
        place(16'hC001, 8'h4C, 8'h00, 8'h02, 3, 0);
`endif
        place(16'h0200, 8'hA9, 8'h10, 8'h00, 2, 1);
        place(16'h0202, 8'h8D, 8'h34, 8'h12, 3, 1);
        place(16'h0205, 8'h20, 8'h00, 8'h40, 3, 1);
        place(16'h0208, 8'h6C, 8'h00, 8'h50, 3, 1);
        place(16'h020B, 8'hB9, 8'h11, 8'h22, 3, 1);
        place(16'h020E, 8'h40, 8'h00, 8'h00, 1, 1);
        place(16'h020F, 8'h0A, 8'h00, 8'h00, 1, 1);
        place(16'h0210, 8'hA2, 8'h55, 8'h00, 2, 1);
        place(16'h0212, 8'hA5, 8'h77, 8'h00, 2, 0);
        place(16'h3000, 8'hE8, 8'h00, 8'h00, 1, 1);
        place(16'hFFFE, 8'hAD, 8'h34, 8'h12, 3, 1);
        place(16'h0001, 8'h4C, 8'h11, 8'h22, 3, 0);
`ifdef INSTR_FETCH_VECTOR_EN
        rd_q.push_back(16'hFFFC);
        rd_q.push_back(16'hFFFD);
        rd_q.push_back(16'hC000);
`else
        rd_q.push_back(16'h0200);
        rd_q.push_back(16'h0201);
`endif

        repeat (2) @(negedge clk);
        chk_zero("rst");
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_rd", mem_rd, 1);
        chk("first_addr", mem_addr, FIRST_RD);
        step();
`ifdef INSTR_FETCH_VECTOR_EN
        take(1, 20);
        wait_valid(20);
        pc_load = 1'b1;
        pc_new  = 16'h0200;
        step();
        pc_load = 1'b0;
`endif

        // Length sweep with ready held high; spacing between transfers is len+2 of the later one.
        base = xfer_cnt;
        take(7, 100);
        for (int i = 1; i < 7; i++)
            chk("gap", xfer_t[base + i] - xfer_t[base + i - 1], sl[i] + 2);

        wait_valid(20);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", instr_valid, 1);
            chk("bp_rd", mem_rd, 0);
            chk("bp_bundle", {instr_opcode, instr_op1, instr_op2, instr_len, instr_pc},
                {8'hA2, 8'h55, 8'h00, 2'd2, 16'h0210});
        end
        step();
        take(1, 10);

        // Redirect while in OP1 of the two-byte instruction at 0212.
        step();
        step();
        chk("op1_rd", mem_rd, 0);
        pc_load = 1'b1;
        pc_new  = 16'h3000;
        step();
        pc_load = 1'b0;
        @(negedge clk);
        chk("redir_valid", instr_valid, 0);
        chk("redir_addr", mem_addr, 16'h3000);

        wait_valid(20);
        nb = xfer_cnt;
        instr_ready = 1'b1;
        pc_load     = 1'b1;
        pc_new      = 16'hFFFE;
        step();
        instr_ready = 1'b0;
        pc_load     = 1'b0;
        chk("sim_xfer", xfer_cnt - nb, 1);
        @(negedge clk);
        chk("sim_valid", instr_valid, 0);

        wait_valid(20);
        take(1, 10);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_zero("midrst");
        repeat (3) step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("end_valid", instr_valid, 1);
        chk("end_bundle", {instr_opcode, instr_op1, instr_op2, instr_len, instr_pc}, PARKED);
        chk("rd_left", rd_q.size(), 0);
        chk("bundle_left", bq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
